// File: rtl/axil_sram_if.sv
// AXI4-Lite bus bundle for the simulation SRAM: AR/R/AW/W/B channels.
// Ports: slave modport faces the memory, master modport faces the requester.
interface axil_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_sram.sv
// AXI4-Lite slave SRAM model, one outstanding access, fixed or LFSR delay.
// Ports: clk, rst_n (sync, active-low), bus (axil_sram_if.slave).
// Build option: define AXIL_SRAM_RAND_DELAY_EN for pseudo-random latency.
module axil_sram #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                FIXED_LAT  = 1,
    parameter logic [2:0]        DELAY_MASK = 3'b111,
    parameter logic [7:0]        LFSR_SEED  = 8'h01
) (
    input  logic          clk,
    input  logic          rst_n,
    axil_sram_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    // One extra bit so BASE_ADDR + size cannot wrap.
    localparam logic [ADDR_W:0] LIMIT =
        {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * STRB_W);

    if (LFSR_SEED == 8'h00 || (DATA_W != 32 && DATA_W != 64)) begin : g_cfg_err
        $error("axil_sram: bad LFSR_SEED or DATA_W");
    end

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              aw_got, w_got;
    logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [7:0]        dly;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q, bresp_q;
    logic              rvalid_q, bvalid_q;

    logic              ar_hs, aw_hs, w_hs;
    logic              wr_start, rd_go, wr_go;
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] wd;
    logic [STRB_W-1:0] ws;
    logic [7:0]        d_new;

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign d_new = {5'b0, lfsr[2:0] & DELAY_MASK};
`else
    assign d_new = 8'(FIXED_LAT);
`endif

    assign bus.arready = rst_n && (state == IDLE);
    assign bus.awready = rst_n && (state == IDLE) && !aw_got && !bus.arvalid;
    assign bus.wready  = rst_n && (state == IDLE) && !w_got && !bus.arvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    // Live handshake values bypass the holding registers.
    assign ra = ar_hs ? bus.araddr : ar_addr_q;
    assign wa = aw_hs ? bus.awaddr : aw_addr_q;
    assign wd = w_hs  ? bus.wdata  : w_data_q;
    assign ws = w_hs  ? bus.wstrb  : w_strb_q;

    assign wr_start = (state == IDLE) && !ar_hs &&
                      (aw_got || aw_hs) && (w_got || w_hs);

    // A zero delay executes on the handshake edge itself.
    assign rd_go = rst_n && ((ar_hs && d_new == 8'd0) ||
                             (state == RD_WAIT && dly == 8'd0));
    assign wr_go = rst_n && ((wr_start && d_new == 8'd0) ||
                             (state == WR_WAIT && dly == 8'd0));

    always_ff @(posedge clk) begin
        if (wr_go && hit(wa)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (ws[i]) mem[idx(wa)][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            dly       <= 8'd0;
            ar_addr_q <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_addr_q <= bus.awaddr;
            if (w_hs) begin
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            unique case (state)
                IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= bus.araddr;
                        state     <= RD_WAIT;
                        dly       <= d_new - 8'd1;
                    end else begin
                        if (aw_hs) aw_got <= 1'b1;
                        if (w_hs)  w_got  <= 1'b1;
                        if (wr_start) begin
                            aw_got <= 1'b0;
                            w_got  <= 1'b0;
                            state  <= WR_WAIT;
                            dly    <= d_new - 8'd1;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (dly != 8'd0) dly <= dly - 8'd1;
                end
                RD_RESP: begin
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (rd_go) begin
                rdata_q  <= hit(ra) ? mem[idx(ra)] : '0;
                rresp_q  <= hit(ra) ? 2'b00 : 2'b10;
                rvalid_q <= 1'b1;
                state    <= RD_RESP;
            end
            if (wr_go) begin
                bresp_q  <= hit(wa) ? 2'b00 : 2'b10;
                bvalid_q <= 1'b1;
                state    <= WR_RESP;
            end
        end
    end
endmodule

// File: tb/tb_axil_sram.sv
// Directed testbench for axil_sram.
// Drives the AXI-Lite bus on negedges and checks responses and latency.
module tb_axil_sram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axil_sram_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_sram #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024),
    .BASE_ADDR(32'h8000_0000), .FIXED_LAT(1),
    .DELAY_MASK(3'b111), .LFSR_SEED(8'h01)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit lat_ok(input int l);
`ifdef AXIL_SRAM_RAND_DELAY_EN
    return (l >= 1) && (l <= 8);
`else
    return l == 2;
`endif
  endfunction

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          output logic [1:0] resp,
                          output int lat);
    int n;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    n = 0;
    #1;
    while (!(bus.awready && bus.wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = 1;
    while (!bus.bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic [31:0] d,
                         output logic [1:0] resp,
                         output int lat);
    int n;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    n = 0;
    #1;
    while (!bus.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    lat = 1;
    while (!bus.rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    d    = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
    int          n;

    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_arready", bus.arready, 1'b1);
    chk("idle_awready", bus.awready, 1'b1);
    chk("idle_rdata", bus.rdata, 32'h0);
    chk("idle_rresp", bus.rresp, 2'b00);
    chk("idle_bresp", bus.bresp, 2'b00);

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
    chk("wr1_bresp", resp, 2'b00);
    chk("wr1_lat", lat_ok(lat), 1'b1);
    do_read(32'h8000_0010, rd, resp, lat);
    chk("rd1_data", rd, 32'hDEAD_BEEF);
    chk("rd1_rresp", resp, 2'b00);
    chk("rd1_lat", lat_ok(lat), 1'b1);

    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, resp, lat);
    chk("wr2_bresp", resp, 2'b00);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp, lat);
    chk("wr3_bresp", resp, 2'b00);
    do_read(32'h8000_0020, rd, resp, lat);
    chk("strb_data", rd, 32'h11BB_33DD);
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, resp, lat);
    chk("strb0_bresp", resp, 2'b00);
    do_read(32'h8000_0020, rd, resp, lat);
    chk("strb0_data", rd, 32'h11BB_33DD);

    bus.wdata  = 32'h5A5A_1234;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    #1;
    chk("wgot_wready", bus.wready, 1'b0);
    repeat (2) @(negedge clk);
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    bus.awaddr  = 32'h8000_0030;
    bus.awvalid = 1'b1;
    #1;
    chk("coll_arready", bus.arready, 1'b1);
    chk("coll_awready", bus.awready, 1'b0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    n = 1;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("coll_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("coll_bvalid", bus.bvalid, 1'b0);
    @(negedge clk);
    bus.rready = 1'b0;
    bus.bready = 1'b1;
    #1;
    chk("coll_awready2", bus.awready, 1'b1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    n = 1;
    while (!bus.bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("coll_bvalid2", bus.bvalid, 1'b1);
    chk("coll_bresp", bus.bresp, 2'b00);
    @(negedge clk);
    bus.bready = 1'b0;
    do_read(32'h8000_0030, rd, resp, lat);
    chk("coll_wdata", rd, 32'h5A5A_1234);

    do_write(32'h8000_0000, 32'h0123_4567, 4'hF, resp, lat);
    chk("base_bresp", resp, 2'b00);
    do_write(32'h8000_0FFC, 32'h0F0F_0F0F, 4'hF, resp, lat);
    chk("top_bresp", resp, 2'b00);
    do_read(32'h8000_0FFC, rd, resp, lat);
    chk("top_rdata", rd, 32'h0F0F_0F0F);
    do_read(32'h7FFF_FFFC, rd, resp, lat);
    chk("oor_rresp", resp, 2'b10);
    chk("oor_rdata", rd, 32'h0);
    do_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF, resp, lat);
    chk("oor_bresp", resp, 2'b10);
    chk("oor_lat", lat_ok(lat), 1'b1);
    do_read(32'h8000_0000, rd, resp, lat);
    chk("oor_nochg", rd, 32'h0123_4567);
    chk("oor_nochg_rresp", resp, 2'b00);

    bus.araddr  = 32'h8000_0020;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 1;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("hold_rvalid", bus.rvalid, 1'b1);
      chk("hold_rdata", bus.rdata, 32'h11BB_33DD);
      chk("hold_rresp", bus.rresp, 2'b00);
      chk("hold_arready", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("hold_done_rvalid", bus.rvalid, 1'b0);
    chk("hold_done_arready", bus.arready, 1'b1);

`ifdef AXIL_SRAM_RAND_DELAY_EN
    begin
      logic [31:0] sb [16];
      bit          seen [9];
      int          distinct;
      logic [31:0] d;
      logic [3:0]  s;
      int          k;
      for (int i = 0; i < 9; i++) seen[i] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        do_write(32'h8000_0100 + 32'(4 * i), d, 4'hF, resp, lat);
        sb[i] = d;
        chk("rnd_init_bresp", resp, 2'b00);
      end
      for (int t = 0; t < 200; t++) begin
        k = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          s = 4'($urandom_range(0, 15));
          do_write(32'h8000_0100 + 32'(4 * k), d, s, resp, lat);
          for (int b = 0; b < 4; b++) begin
            if (s[b]) sb[k][8*b +: 8] = d[8*b +: 8];
          end
          chk("rnd_bresp", resp, 2'b00);
        end else begin
          do_read(32'h8000_0100 + 32'(4 * k), rd, resp, lat);
          chk("rnd_rdata", rd, sb[k]);
          chk("rnd_rresp", resp, 2'b00);
        end
        chk("rnd_lat", lat_ok(lat), 1'b1);
        if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
      end
      distinct = 0;
      for (int i = 1; i < 9; i++) if (seen[i]) distinct++;
      chk("rnd_distinct_ge3", (distinct >= 3), 1'b1);
    end
`else
    bus.awaddr  = 32'h8000_0010;
    bus.wdata   = 32'hFFFF_FFFF;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wrst_bvalid", bus.bvalid, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("wrst_bvalid2", bus.bvalid, 1'b0);
    do_read(32'h8000_0010, rd, resp, lat);
    chk("wrst_nochg", rd, 32'hDEAD_BEEF);
`endif

    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rrst_rvalid", bus.rvalid, 1'b0);
    chk("rrst_arready", bus.arready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rrst_idle", bus.arready, 1'b1);
    repeat (3) @(negedge clk);
    chk("rrst_rvalid2", bus.rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axil_sram.md
Name: axil_sram

Overview:
- Parametrised AXI4-Lite slave SRAM model serving both read and write channels from an internal word array.
- Access latency is fixed or pseudo-random.
- Out-of-range addresses return an error response.
- Sits behind the IFU/LSU AXI-Lite masters (or an arbiter/xbar) as the simulation main memory, so core handshake robustness can be exercised under variable latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.
- DEPTH, 1024, number of DATA_W words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- FIXED_LAT, 1, wait cycles between address accept and response when random delay is compiled out.
- DELAY_MASK, 3'b111, mask applied to LFSR for random delay (max wait 7).
- LFSR_SEED, 8'h01, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- araddr  in  ADDR_W  read address
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  R valid
- rready  in  1  R ready
- awaddr  in  ADDR_W  write address
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_W  write data
- wstrb  in  STRB_W  byte strobes
- wvalid  in  1  W valid
- wready  out  1  W ready
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready

Behaviour:
- **Reset (rst_n low at clk edge):**
  - state=IDLE, aw_got=0, w_got=0, delay counter=0, LFSR=LFSR_SEED.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - All ready outputs are forced 0 while rst_n is low. Memory contents are not reset.
  - Reset mid-transaction abandons it: no memory update, no response.
- **States:** IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- **Ready signals:**
  - arready = (state==IDLE).
  - awready = (state==IDLE) && !aw_got && !arvalid.
  - wready = (state==IDLE) && !w_got && !arvalid.
  - Read wins a same-cycle AR/AW collision. AW/W held in aw_got/w_got survive an intervening read.
- **AW/W capture:** independent in IDLE; address, data and strobe are latched on their handshakes.
- **Write start:** when (aw_got or AW handshake) and (w_got or W handshake) in the same cycle, go to WR_WAIT and clear aw_got/w_got. The same-cycle AW+W handshake is a legal one-shot case.
- **Read start:** AR handshake in IDLE latches araddr and goes to RD_WAIT.
- **Delay load:** on entry to RD_WAIT/WR_WAIT, delay counter D = FIXED_LAT (or random value, see Optional Feature).
- **Wait count:** counter decrements each cycle while >0. When 0, the access executes and the state moves to RD_RESP/WR_RESP.
- **Latency:** for an address handshake at cycle T, rvalid/bvalid first assert at T+1+D.
- **Address decode:**
  - idx = (addr - BASE_ADDR) >> log2(STRB_W); low offset bits are ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*STRB_W, with compare wide enough to avoid wrap.
  - In range: rresp/bresp = 2'b00 (OKAY).
  - Out of range: rresp/bresp = 2'b10 (SLVERR), rdata=0, no memory write.
- **Write:** byte lanes with wstrb[i]=1 are updated; other lanes are unchanged. wstrb=0 is legal: OKAY response, no change.
- **Read:** rdata is registered and reflects all previously completed writes.
- **Response hold:** RD_RESP holds rvalid/rdata/rresp stable until rready; the cycle after the handshake is IDLE with rvalid=0. WR_RESP behaves the same with bvalid/bready.
- **Throughput:** a back-to-back transaction is accepted no earlier than the cycle after the response handshake, i.e. at most one outstanding transaction.

Optional Feature:
- Macro: AXIL_SRAM_RAND_DELAY_EN.
- **Defined:**
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advances every cycle out of reset.
  - D = lfsr[2:0] & DELAY_MASK, sampled on the address handshake cycle.
- **Undefined:** no LFSR logic; D = FIXED_LAT always.

Test Plan:
- Write 0xDEADBEEF to 0x8000_0010 with wstrb=4'hF (AW and W same cycle), then read 0x8000_0010 -> bresp=00, rdata=0xDEADBEEF, rresp=00; fixed build: rvalid at T+2 with FIXED_LAT=1.
- Partial strobe: write 0x11223344 to 0x8000_0020 with strb F, then 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
- W presented 3 cycles before AW, then AR and AW asserted in the same cycle -> read handshakes first; the write completes after the R handshake with correct data.
- Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) -> rresp=10 with rdata=0; bresp=10; a subsequent in-range read shows memory unchanged.
- Hold rready=0 for 5 cycles in RD_RESP -> rvalid, rdata and rresp are stable; arready=0 throughout.
- AXIL_SRAM_RAND_DELAY_EN build, 200 random reads/writes with a scoreboard:
  - all latencies fall within 1..8 cycles and at least 3 distinct values occur;
  - data matches the scoreboard;
  - rst_n pulsed low mid-RD_WAIT -> rvalid=0 and IDLE afterwards.
